// File: rtl/fp8_add_scheduler.sv
// fp8_add_scheduler
// Shares one combinational E4M3 FP8 adder among NUM_REQ requesters. A round-robin
// arbiter accepts one operand pair while idle. The pair is registered onto the
// adder bus, and the sum is captured one cycle later. The sum is returned with
// the owner's ID on a valid/ready response port. If either operand has a zero
// magnitude, the adder is bypassed and the other operand is returned unchanged,
// because the adder always assumes an implicit leading one.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   req_valid     per-requester operand valid
//   req_ready     per-requester accept (combinational, one-hot or zero)
//   req_a, req_b  operands, requester i at [8i+7:8i]
//   add_a, add_b  registered operands driven to the shared adder
//   add_y         combinational adder sum of add_a/add_b
//   rsp_valid     result valid, held until rsp_ready
//   rsp_ready     result consumer ready
//   rsp_id        requester owning rsp_y
//   rsp_y         E4M3 sum
//   busy          high whenever the scheduler is not idle
//   op_count      completed response handshakes, wrapping
module fp8_add_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [7:0]             add_a,
  output logic [7:0]             add_b,
  input  logic [7:0]             add_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [7:0]             rsp_y,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MAG_W  = 7;
  localparam int unsigned SUM_W  = ID_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state,     state_n;
  logic [ID_W-1:0]   rr_ptr,    rr_ptr_n;
  logic [DATA_W-1:0] add_a_n,   add_b_n;
  logic              byp_a,     byp_a_n;
  logic              byp_b,     byp_b_n;
  logic              rsp_valid_n;
  logic [ID_W-1:0]   rsp_id_n;
  logic [DATA_W-1:0] rsp_y_n;
  logic              busy_n;
  logic [CNT_W-1:0]  op_count_n;

  logic              grant_found;
  logic [ID_W-1:0]   grant;
  logic [SUM_W-1:0]  cand;
  logic              cand_valid;
  logic [DATA_W-1:0] grant_a, grant_b;
  logic [ID_W-1:0]   grant_next;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping at NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    cand_valid  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      cand_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cand == SUM_W'(i)) begin
          cand_valid = req_valid[i];
        end
      end
      if (!grant_found && cand_valid) begin
        grant_found = 1'b1;
        grant       = cand[ID_W-1:0];
      end
    end
  end

  // Operand select for the granted requester
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        grant_a = req_a[DATA_W*i +: DATA_W];
        grant_b = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  // Pointer after the granted index; explicit wrap handles non power-of-two NUM_REQ
  always_comb begin
    if (grant == ID_W'(NUM_REQ - 1)) begin
      grant_next = '0;
    end else begin
      grant_next = grant + ID_W'(1);
    end
  end

  // Accept strobe is only offered while idle
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == IDLE) && grant_found && (grant == ID_W'(i));
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    add_a_n     = add_a;
    add_b_n     = add_b;
    byp_a_n     = byp_a;
    byp_b_n     = byp_b;
    rsp_valid_n = rsp_valid;
    rsp_id_n    = rsp_id;
    rsp_y_n     = rsp_y;
    op_count_n  = op_count;

    case (state)
      IDLE: begin
        if (grant_found) begin
          add_a_n  = grant_a;
          add_b_n  = grant_b;
          rsp_id_n = grant;
          rr_ptr_n = grant_next;
          byp_a_n  = (grant_a[MAG_W-1:0] == '0);
          byp_b_n  = (grant_b[MAG_W-1:0] == '0);
          state_n  = EXEC;
        end
      end
      EXEC: begin
        // A zero operand returns the other one verbatim, sign included; A wins ties
        if (byp_a) begin
          rsp_y_n = add_b;
        end else if (byp_b) begin
          rsp_y_n = add_a;
        end else begin
          rsp_y_n = add_y;
        end
        rsp_valid_n = 1'b1;
        state_n     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          op_count_n  = op_count + CNT_W'(1);
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      add_a     <= '0;
      add_b     <= '0;
      byp_a     <= 1'b0;
      byp_b     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      add_a     <= add_a_n;
      add_b     <= add_b_n;
      byp_a     <= byp_a_n;
      byp_b     <= byp_b_n;
      rsp_valid <= rsp_valid_n;
      rsp_id    <= rsp_id_n;
      rsp_y     <= rsp_y_n;
      busy      <= busy_n;
      op_count  <= op_count_n;
    end
  end

endmodule

// File: tb/tb_fp8_add_scheduler.sv
// tb_fp8_add_scheduler
// Directed and randomized bench for fp8_add_scheduler. A transaction-level model
// tracks the round-robin pointer, the pending response, its due cycle and the
// completed-op count. A stand-in adder drives add_y. Every cycle is checked at
// the falling edge.
module tb_fp8_add_scheduler;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [8*N-1:0]  req_a;
  logic [8*N-1:0]  req_b;
  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic [7:0]      add_y;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [7:0]      rsp_y;
  logic            busy;
  logic [CW-1:0]   op_count;

  logic [N-1:0]    rv;
  logic [7:0]      ra [N];
  logic [7:0]      rb [N];
  logic            force_en;
  logic [7:0]      force_val;

  int  vectors;
  int  miscompares;
  int  cyc;
  int  pend;
  int  acc_cyc;
  int  m_id;
  int  m_a;
  int  m_b;
  int  m_y;
  int  ptr;
  int  ops;
  bit  refill;
  bit  rand_mode;
  int  dut_gnt [$];
  int  dut_acc [$];
  int  dut_y [$];

  always #5 clk = ~clk;

  always_comb begin
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = ra[i];
      req_b[8*i +: 8] = rb[i];
    end
  end

  // Stand-in adder: 1.0+1.0 gives 2.0, otherwise a scrambled but deterministic value
  function automatic logic [7:0] mock_add(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h38 && b == 8'h38) return 8'h40;
    return (a ^ 8'h5A) + {b[3:0], b[7:4]};
  endfunction

  assign add_y = force_en ? force_val : mock_add(add_a, add_b);

  fp8_add_scheduler #(.NUM_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Expected sum: zero-magnitude operand bypasses the adder, A checked first
  function automatic int ref_sum(input logic [7:0] a, input logic [7:0] b);
    if (a[6:0] == 7'd0) return int'(b);
    if (b[6:0] == 7'd0) return int'(a);
    return force_en ? int'(force_val) : int'(mock_add(a, b));
  endfunction

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) begin
      if (rv[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rnd_op();
    logic [7:0] v;
    v = 8'($urandom);
    if ($urandom_range(0, 3) == 0) v[6:0] = 7'd0;
    return v;
  endfunction

  function automatic int q_at(input int q [$], input int k);
    if (k < 0 || k >= q.size()) return -1;
    return q[k];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model, then update requesters after the edge
  task automatic cycle();
    int g;
    int acc;
    logic [N-1:0] exp_rdy;
    bit exp_valid;
    acc = -1;
    @(negedge clk);
    g = rr_pick();
    exp_rdy = '0;
    if (pend == 0 && g >= 0) exp_rdy[g] = 1'b1;
    exp_valid = (pend != 0) && (cyc >= acc_cyc + 2);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(pend));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_y", 32'(rsp_y), 32'(m_y));
    end
    if (pend != 0 && cyc == acc_cyc + 1) begin
      chk("add_a", 32'(add_a), 32'(m_a));
      chk("add_b", 32'(add_b), 32'(m_b));
    end
    chk("op_count", 32'(op_count), 32'(ops));
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          dut_gnt.push_back(i);
          dut_acc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) dut_y.push_back(int'(rsp_y));
    end
    if (rst) begin
      pend = 0;
      ptr  = 0;
      ops  = 0;
    end else if (pend == 0 && g >= 0) begin
      pend    = 1;
      acc_cyc = cyc;
      m_id    = g;
      m_a     = int'(ra[g]);
      m_b     = int'(rb[g]);
      m_y     = ref_sum(ra[g], rb[g]);
      ptr     = (g + 1) % N;
      acc     = g;
    end else if (exp_valid && rsp_ready) begin
      pend = 0;
      ops  = (ops + 1) % (1 << CW);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      if (refill) begin
        ra[acc] = rnd_op();
        rb[acc] = rnd_op();
      end else begin
        rv[acc] = 1'b0;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = rnd_op();
          rb[i] = rnd_op();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (pend == 0) begin
        force_en  = ($urandom_range(0, 3) == 0);
        force_val = 8'($urandom);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend != 0 || rv != '0) && n < budget) begin
      cycle();
      n++;
    end
    vectors++;
    assert (pend == 0 && rv == '0) else begin
      miscompares++;
      $error("FAIL drain_timeout: observed pending=%0d valid=%b expected idle", pend, rv);
    end
  endtask

  task automatic issue(input int r, input logic [7:0] a, input logic [7:0] b);
    rv[r] = 1'b1;
    ra[r] = a;
    rb[r] = b;
    drain(12);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    cyc = 0; pend = 0; acc_cyc = 0; m_id = 0; m_a = 0; m_b = 0; m_y = 0; ptr = 0; ops = 0;
    refill = 1'b0; rand_mode = 1'b0;
    rv = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = 8'h00;
      rb[i] = 8'h00;
    end
    rsp_ready = 1'b0; force_en = 1'b0; force_val = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset values
    chk("reset_add_a", 32'(add_a), 32'h00);
    chk("reset_add_b", 32'(add_b), 32'h00);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_y", 32'(rsp_y), 32'h00);

    // Single op: 1.0 + 1.0
    rsp_ready = 1'b1;
    issue(0, 8'h38, 8'h38);
    chk("single_grant", 32'(q_at(dut_gnt, 0)), 32'(0));
    chk("single_y", 32'(q_at(dut_y, dut_y.size() - 1)), 32'h40);
    chk("single_count", 32'(op_count), 32'd1);

    // Round robin with every requester continuously valid
    pulse_reset();
    dut_gnt.delete();
    dut_acc.delete();
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b1;
      ra[i] = rnd_op();
      rb[i] = rnd_op();
    end
    refill = 1'b1;
    repeat (13) cycle();
    refill = 1'b0;
    drain(30);
    for (int k = 0; k < 5; k++) chk("rr_grant", 32'(q_at(dut_gnt, k)), 32'(k % N));
    for (int k = 1; k < 5; k++) chk("rr_interval", 32'(q_at(dut_acc, k) - q_at(dut_acc, k - 1)), 32'd3);

    // Backpressure: response held for 5 cycles with another request waiting
    rsp_ready = 1'b0;
    rv[1] = 1'b1; ra[1] = 8'h40; rb[1] = 8'h3A;
    cycle();
    cycle();
    rv[2] = 1'b1; ra[2] = 8'h44; rb[2] = 8'h30;
    repeat (6) cycle();
    chk("bp_held_valid", 32'(rsp_valid), 32'd1);
    chk("bp_held_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    drain(12);
    chk("bp_next_grant", 32'(q_at(dut_gnt, dut_gnt.size() - 1)), 32'd2);

    // Zero bypass with the adder forced to 0xFF
    force_en = 1'b1; force_val = 8'hFF;
    issue(3, 8'h00, 8'h44);
    chk("byp_a_zero", 32'(q_at(dut_y, dut_y.size() - 1)), 32'h44);
    issue(3, 8'h3C, 8'h80);
    chk("byp_b_negzero", 32'(q_at(dut_y, dut_y.size() - 1)), 32'h3C);
    issue(3, 8'h00, 8'h80);
    chk("byp_both_zero", 32'(q_at(dut_y, dut_y.size() - 1)), 32'h80);
    issue(3, 8'h3C, 8'h44);
    chk("byp_none_forced", 32'(q_at(dut_y, dut_y.size() - 1)), 32'hFF);
    force_en = 1'b0;

    // Reset during EXEC
    rv[1] = 1'b1; ra[1] = 8'h41; rb[1] = 8'h42;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_exec_busy", 32'(busy), 32'd0);
    chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec_count", 32'(op_count), 32'd0);

    // Reset during RESP with the pointer left at 3
    rsp_ready = 1'b0;
    rv[2] = 1'b1; ra[2] = 8'h33; rb[2] = 8'h21;
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_resp_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    rv[2] = 1'b1; ra[2] = 8'h11; rb[2] = 8'h22;
    rv[3] = 1'b1; ra[3] = 8'h33; rb[3] = 8'h44;
    cycle();
    chk("rst_first_grant", 32'(q_at(dut_gnt, dut_gnt.size() - 1)), 32'd2);
    rsp_ready = 1'b1;
    drain(20);

    // Randomized traffic
    rand_mode = 1'b1;
    repeat (400) cycle();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    drain(40);
    force_en = 1'b0;

    // Counter wrap: 17 completions on a 4-bit counter
    pulse_reset();
    for (int k = 0; k < 17; k++) issue(k % N, rnd_op(), rnd_op());
    chk("wrap_count", 32'(op_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp8_add_scheduler.md
Name: fp8_add_scheduler

Overview:
- Shares one combinational E4M3 (1-4-3) FP8 adder among NUM_REQ requesters using round-robin arbitration.
- Registers the granted operands onto the adder input bus, captures the adder result one cycle later and returns it with the requester ID on a valid/ready response port.
- Handles zero operands by bypass, because the adder always assumes an implicit leading 1.
- Sits between the vector/accumulate front-ends and the single shared adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; combinational, one-hot or zero
req_a  in  8*NUM_REQ  operand A of requester i at [8i+7:8i]
req_b  in  8*NUM_REQ  operand B of requester i at [8i+7:8i]
add_a  out  8  registered operand A to shared adder
add_b  out  8  registered operand B to shared adder
add_y  in  8  combinational adder sum of add_a/add_b
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_id  out  ID_W  index of requester that owns rsp_y
rsp_y  out  8  E4M3 sum
busy  out  1  high whenever state != IDLE
op_count  out  CNT_W  number of completed response handshakes, wraps

Behaviour:
- Clock is clk; reset is synchronous active-high on rst.
- FSM states: IDLE, EXEC, RESP. Reset gives state=IDLE, rr_ptr=0, add_a=add_b=0, rsp_valid=0, rsp_id=0, rsp_y=0, op_count=0, busy=0.
- Arbitration in IDLE:
  - grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 only in IDLE while some req_valid is high; req_ready is 0 in every other state.
- IDLE -> EXEC on an accept edge (req_valid[g] & req_ready[g]):
  - add_a<=req_a[g], add_b<=req_b[g], rsp_id<=g.
  - rr_ptr<=(g+1) mod NUM_REQ.
  - Latch the bypass select: byp_a=(req_a[g][6:0]==0), byp_b=(req_b[g][6:0]==0).
- EXEC -> RESP unconditionally after one cycle, capturing rsp_y:
  - byp_a: rsp_y<=add_b.
  - else byp_b: rsp_y<=add_a.
  - else rsp_y<=add_y.
  - Set rsp_valid<=1.
- RESP:
  - rsp_valid, rsp_id and rsp_y are held stable until rsp_ready=1.
  - On that edge: rsp_valid<=0, op_count<=op_count+1 (wraps at 2**CNT_W), state<=IDLE.
- Latency: accept edge T, rsp_valid high from cycle T+2. Minimum issue interval is 3 cycles; no new accept occurs in the cycle RESP completes.
- add_a/add_b hold their last value after EXEC. add_y is sampled only in EXEC.
- Requesters must hold req_valid and operands until accepted. The scheduler does not check this.
- Signed zero: bypass passes the other operand unchanged, including its sign. 0x00+0x80 returns 0x80 (byp_a wins).
- NaN / overflow are not detected: add_y is passed through unmodified.
- rst asserted in any state aborts the in-flight operation. The pending response is dropped and all registers return to reset values on the next edge.
- rsp_ready high while rsp_valid=0 has no effect.
- NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Single op: req0 a=0x38, b=0x38 (1.0+1.0), adder model returns 0x40, rsp_ready=1 -> req_ready[0] high for 1 cycle; rsp_valid at T+2, rsp_id=0, rsp_y=0x40, op_count=1.
- Round-robin: all 4 req_valid held high -> grant order 0,1,2,3,0; each response carries the matching rsp_id; issue interval is exactly 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_y/rsp_id stable, req_ready all 0, busy=1; on rsp_ready=1 the FSM returns to IDLE and the next grant follows.
- Zero bypass: a=0x00, b=0x44 with adder model forced to 0xFF -> rsp_y=0x44; a=0x3C, b=0x80 -> rsp_y=0x3C; a=0x00, b=0x80 -> rsp_y=0x80.
- Reset mid-op: assert rst during EXEC and during RESP -> next cycle rsp_valid=0, busy=0, op_count=0, rr_ptr=0; first post-reset grant goes to the lowest valid index.
- Counter wrap (CNT_W=4): 17 completed ops -> op_count reads 1.
